// File: rtl/hd63701_biram_arbiter.sv
// HD63701 128-byte built-in work RAM with a single port shared between the CPU core
// (always wins) and a host/debug port that takes only the cycles the core leaves free.
module hd63701_biram_arbiter #(
    parameter logic [8:0]  RAM_PAGE = 9'h001,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        mcu_clx2,
    input  logic        mcu_rst,
    input  logic [15:0] mcu_ad,
    input  logic        mcu_wr,
    input  logic [7:0]  mcu_do,
    output logic        en_biram,
    output logic [7:0]  biramd,
    input  logic        host_req,
    input  logic        host_wr,
    input  logic [6:0]  host_addr,
    input  logic [7:0]  host_len,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        host_rvalid,
    input  logic        host_rready,
    output logic        host_busy,
    output logic        host_done,
    output logic        host_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_CAPT, RD_OUT} state_t;

    state_t         state, state_nx;
    logic [7:0]     ram [0:127];
    logic [6:0]     addr_q;
    logic [7:0]     len_q;
    logic [7:0]     wdata_q;
    logic [CW-1:0]  tmo_cnt;
    logic           len0_done_q;
    logic           host_we, host_re, tmo_hit, pop, blocked;
    logic [6:0]     ram_addr;
    logic           ram_we, ram_re;
    logic [7:0]     ram_wdata;

    assign en_biram  = (mcu_ad[15:7] == RAM_PAGE);
    assign host_busy = (state != IDLE);
    assign pop       = host_rvalid & host_rready;
    assign tmo_hit   = (tmo_cnt == CW'(TIMEOUT - 1));
    assign blocked   = en_biram & ((state == WRITE) | (state == RD_ISSUE));

    // Single RAM port: the core owns every cycle it addresses the window.
    assign ram_addr  = en_biram ? mcu_ad[6:0] : addr_q;
    assign ram_wdata = en_biram ? mcu_do : wdata_q;
    assign ram_we    = (en_biram & mcu_wr) | host_we;
    assign ram_re    = (en_biram & ~mcu_wr) | host_re;

    always_ff @(posedge mcu_clx2 or posedge mcu_rst) begin
        if (mcu_rst) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        host_we   = 1'b0;
        host_re   = 1'b0;
        host_ack  = 1'b0;
        host_err  = 1'b0;
        host_done = len0_done_q;
        unique case (state)
            IDLE: begin
                if (host_req) begin
                    host_ack = 1'b1;
                    if (host_wr)             state_nx = WRITE;
                    else if (host_len != '0) state_nx = RD_ISSUE;
                end
            end
            WRITE: begin
                if (!en_biram) begin
                    host_we   = 1'b1;
                    host_done = 1'b1;
                    state_nx  = IDLE;
                end else if (tmo_hit) begin
                    host_err = 1'b1;
                    state_nx = IDLE;
                end
            end
            RD_ISSUE: begin
                if (!en_biram) begin
                    host_re  = 1'b1;
                    state_nx = RD_CAPT;
                end else if (tmo_hit) begin
                    host_err = 1'b1;
                    state_nx = IDLE;
                end
            end
            RD_CAPT: state_nx = RD_OUT;
            RD_OUT: begin
                if (pop) begin
                    if (len_q == 8'd1) begin
                        host_done = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        state_nx = RD_ISSUE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge mcu_clx2) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge mcu_clx2 or posedge mcu_rst) begin
        if (mcu_rst) begin
            biramd      <= '0;
            host_rdata  <= '0;
            host_rvalid <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            tmo_cnt     <= '0;
            len0_done_q <= 1'b0;
        end else begin
            len0_done_q <= host_ack & ~host_wr & (host_len == '0);
            if (ram_re) biramd <= ram[ram_addr];
            if (host_ack) begin
                addr_q  <= host_addr;
                len_q   <= host_len;
                wdata_q <= host_wdata;
            end
            // biramd still holds the host byte here: the core read of this cycle lands at the same edge.
            if (state == RD_CAPT) begin
                host_rdata  <= biramd;
                host_rvalid <= 1'b1;
            end else if (pop) begin
                host_rvalid <= 1'b0;
                addr_q      <= addr_q + 7'd1;
                len_q       <= len_q - 8'd1;
            end
            if (blocked && !tmo_hit) tmo_cnt <= tmo_cnt + CW'(1);
            else                     tmo_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_hd63701_biram_arbiter.sv
// Directed bench for hd63701_biram_arbiter: core slots, host writes/bursts, timeout, reset abort.
module tb_hd63701_biram_arbiter;

    logic        clk = 1'b0;
    logic        mcu_rst = 1'b0;
    logic [15:0] mcu_ad = 16'h1000;
    logic        mcu_wr = 1'b0;
    logic [7:0]  mcu_do = '0;
    logic        en_biram;
    logic [7:0]  biramd;
    logic        host_req = 1'b0;
    logic        host_wr = 1'b0;
    logic [6:0]  host_addr = '0;
    logic [7:0]  host_len = '0;
    logic [7:0]  host_wdata = '0;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        host_rvalid;
    logic        host_rready = 1'b0;
    logic        host_busy;
    logic        host_done;
    logic        host_err;

    always #5 clk = ~clk;

    hd63701_biram_arbiter #(.RAM_PAGE(9'h001), .TIMEOUT(16)) dut (
        .mcu_clx2(clk), .mcu_rst(mcu_rst), .mcu_ad(mcu_ad), .mcu_wr(mcu_wr), .mcu_do(mcu_do),
        .en_biram(en_biram), .biramd(biramd),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_len(host_len),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .host_rready(host_rready), .host_busy(host_busy),
        .host_done(host_done), .host_err(host_err)
    );

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  model [128];
    logic [7:0]  sb_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic core_write(input logic [6:0] off, input logic [7:0] d);
        next_cycle();
        mcu_ad = {9'h001, off};
        mcu_wr = 1'b1;
        mcu_do = d;
        model[off] = d;
        next_cycle();
        mcu_wr = 1'b0;
        mcu_ad = 16'h1000;
    endtask

    task automatic core_read(input logic [6:0] off, input string tag);
        next_cycle();
        mcu_ad = {9'h001, off};
        next_cycle();
        mcu_ad = 16'h1000;
        sample();
        chk(tag, biramd, model[off]);
    endtask

    task automatic run_burst(input logic [6:0] a, input logic [7:0] len,
                             input int unsigned stall, input string tag);
        int unsigned pops = 0;
        int unsigned dones = 0;
        int unsigned done_at = 0;
        int unsigned first = (stall + 1 > 3) ? stall + 1 : 3;
        next_cycle();
        host_req = 1'b1; host_wr = 1'b0; host_addr = a; host_len = len;
        host_rready = (stall == 0);
        sample();
        chk({tag, "_ack"}, host_ack, 1);
        for (int unsigned k = 0; k < len; k++) sb_q.push_back(model[7'(a + k)]);
        for (int unsigned i = 1; i <= len * 3 + stall + 4; i++) begin
            next_cycle();
            host_req = 1'b0;
            host_rready = (i > stall);
            sample();
            if (host_rvalid && host_rready) begin
                pops++;
                if (sb_q.size() != 0) chk({tag, "_data"}, host_rdata, sb_q.pop_front());
            end
            if (host_done) begin
                dones++;
                done_at = i;
            end
            chk({tag, "_noerr"}, host_err, 0);
        end
        chk({tag, "_pops"}, pops, len);
        chk({tag, "_dones"}, dones, 1);
        chk({tag, "_done_at"}, done_at, first + 3 * (len - 1));
        chk({tag, "_idle"}, host_busy, 0);
        chk({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        // reset
        #2 mcu_rst = 1'b1;
        next_cycle(); next_cycle();
        sample();
        chk("rst_biramd", biramd, 0);
        chk("rst_rdata", host_rdata, 0);
        chk("rst_rvalid", host_rvalid, 0);
        chk("rst_busy", host_busy, 0);
        chk("rst_done", host_done, 0);
        chk("rst_err", host_err, 0);
        chk("rst_ack", host_ack, 0);
        next_cycle();
        mcu_rst = 1'b0;

        // RAM window decode boundaries
        mcu_ad = 16'h007F; #1 chk("en_007f", en_biram, 0);
        mcu_ad = 16'h0080; #1 chk("en_0080", en_biram, 1);
        mcu_ad = 16'h00FF; #1 chk("en_00ff", en_biram, 1);
        mcu_ad = 16'h0100; #1 chk("en_0100", en_biram, 0);
        mcu_ad = 16'h1000;

        // core only: write then read, biramd one cycle after the read
        core_write(7'h10, 8'hA5);
        core_read(7'h10, "core_rd_a5");
        chk("core_host_idle", host_busy, 0);

        // host single write on a free slot
        next_cycle();
        host_req = 1'b1; host_wr = 1'b1; host_addr = 7'h10; host_wdata = 8'h3C;
        sample();
        chk("hw_ack", host_ack, 1);
        chk("hw_done_early", host_done, 0);
        next_cycle();
        host_req = 1'b0;
        sample();
        chk("hw_done", host_done, 1);
        chk("hw_busy", host_busy, 1);
        model[7'h10] = 8'h3C;
        next_cycle();
        sample();
        chk("hw_idle", host_busy, 0);
        chk("hw_done_pulse", host_done, 0);
        core_read(7'h10, "hw_ram");

        // zero-length read: done next cycle, never busy
        next_cycle();
        host_req = 1'b1; host_wr = 1'b0; host_len = 8'd0;
        sample();
        chk("len0_ack", host_ack, 1);
        chk("len0_done_early", host_done, 0);
        next_cycle();
        host_req = 1'b0;
        sample();
        chk("len0_done", host_done, 1);
        chk("len0_busy", host_busy, 0);
        next_cycle();
        sample();
        chk("len0_pulse", host_done, 0);

        // burst across the 7-bit wrap
        core_write(7'h7E, 8'h81);
        core_write(7'h7F, 8'h82);
        core_write(7'h00, 8'h83);
        run_burst(7'h7E, 8'd3, 0, "burst_wrap");

        // burst with consumer backpressure
        core_write(7'h05, 8'h5A);
        core_write(7'h06, 8'hC3);
        run_burst(7'h05, 8'd2, 6, "burst_stall");

        // core holds the port for 5 cycles while a host write waits
        for (int unsigned k = 0; k < 5; k++) core_write(7'(8'h20 + k), 8'(8'h50 + k));
        next_cycle();
        host_req = 1'b1; host_wr = 1'b1; host_addr = 7'h30; host_wdata = 8'h77;
        sample();
        chk("cw_ack", host_ack, 1);
        for (int unsigned i = 1; i <= 5; i++) begin
            next_cycle();
            host_req = 1'b0;
            mcu_ad = {9'h001, 7'(8'h20 + i - 1)};
            sample();
            chk("cw_wait_done", host_done, 0);
            chk("cw_wait_busy", host_busy, 1);
            if (i >= 2) chk("cw_core_rd", biramd, model[7'(8'h20 + i - 2)]);
        end
        next_cycle();
        mcu_ad = 16'h1000;
        sample();
        chk("cw_done", host_done, 1);
        chk("cw_core_rd_last", biramd, model[7'h24]);
        model[7'h30] = 8'h77;
        next_cycle();
        sample();
        chk("cw_idle", host_busy, 0);
        core_read(7'h30, "cw_ram");

        // port stuck on the core: host write times out after 16 waits
        core_write(7'h31, 8'h11);
        next_cycle();
        host_req = 1'b1; host_wr = 1'b1; host_addr = 7'h31; host_wdata = 8'hEE;
        mcu_ad = 16'h00C0;
        sample();
        chk("to_ack", host_ack, 1);
        for (int unsigned i = 1; i <= 16; i++) begin
            next_cycle();
            host_req = 1'b0;
            sample();
            chk("to_err", host_err, (i == 16) ? 1 : 0);
            chk("to_busy", host_busy, 1);
            chk("to_nodone", host_done, 0);
        end
        next_cycle();
        sample();
        chk("to_idle", host_busy, 0);
        chk("to_err_pulse", host_err, 0);
        mcu_ad = 16'h1000;
        core_read(7'h31, "to_ram_kept");

        // reset mid-burst while a byte is being held
        next_cycle();
        host_req = 1'b1; host_wr = 1'b0; host_addr = 7'h40; host_len = 8'd4; host_rready = 1'b0;
        for (int unsigned i = 1; i <= 3; i++) begin
            next_cycle();
            host_req = 1'b0;
        end
        sample();
        chk("mr_rvalid", host_rvalid, 1);
        #2 mcu_rst = 1'b1;
        #1;
        chk("mr_rvalid_drop", host_rvalid, 0);
        chk("mr_busy_drop", host_busy, 0);
        chk("mr_no_done", host_done, 0);
        chk("mr_no_err", host_err, 0);
        chk("mr_rdata", host_rdata, 0);
        next_cycle();
        next_cycle();
        mcu_rst = 1'b0;
        host_rready = 1'b1;
        sample();
        chk("mr_after_busy", host_busy, 0);
        chk("mr_after_done", host_done, 0);
        chk("mr_after_err", host_err, 0);
        chk("mr_after_rvalid", host_rvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
